// File: rtl/led_div_seq.sv
// Divisor sequencer for the LED blink counter: steps a divisor table, honours a software override.
// Define LED_SEQ_AUTOCLR_EN to let the sequencer clear the blink interrupt latch itself.
module led_div_seq #(
  parameter int NSTEPS = 4,
  parameter int DIV_W  = 12,
  parameter int HOLD_W = 8,
  localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1
) (
  input  logic                     clk100,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic [NSTEPS*DIV_W-1:0]  step_div_i,
  input  logic [NSTEPS*HOLD_W-1:0] step_hold_i,
  input  logic                     sw_req_i,
  input  logic [DIV_W-1:0]         sw_div_i,
  output logic                     sw_ack_o,
  input  logic                     led_i,
  input  logic                     int_i,
  output logic                     int_clr_o,
  output logic [DIV_W-1:0]         div_o,
  output logic                     wren_o,
  output logic [STEP_W-1:0]        step_o,
  output logic                     busy_o,
  output logic                     wrap_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, SW} state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic [STEP_W-1:0]   r_step;
  logic [HOLD_W-1:0]   r_tog_cnt;
  logic                r_mask;
  logic                r_led_q;
  logic [DIV_W-1:0]    r_div;
  logic                r_wren;
  logic                r_ack;
  logic                r_wrap;
  logic                r_busy;

  logic [STEP_W-1:0]   w_step;
  logic [HOLD_W-1:0]   w_tog_cnt;
  logic                w_mask;
  logic [DIV_W-1:0]    w_div;
  logic                w_wren;
  logic                w_ack;
  logic                w_wrap;

  logic                w_toggle;
  logic [HOLD_W-1:0]   w_hold;
  logic [HOLD_W-1:0]   w_hold_eff;
  logic [HOLD_W:0]     w_cnt_inc;
  logic                w_done;
  logic [DIV_W-1:0]    w_tab_div;

  assign w_toggle   = led_i ^ r_led_q;
  assign w_hold     = step_hold_i[int'(r_step)*HOLD_W +: HOLD_W];
  assign w_tab_div  = step_div_i[int'(r_step)*DIV_W +: DIV_W];
  // A zero hold count still needs one counted toggle before advancing
  assign w_hold_eff = (w_hold == '0) ? HOLD_W'(1) : w_hold;
  assign w_cnt_inc  = {1'b0, r_tog_cnt} + (HOLD_W+1)'(1);
  assign w_done     = (r_state == RUN) && w_toggle && !r_mask &&
                      (w_cnt_inc >= {1'b0, w_hold_eff});

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_tog_cnt <= '0;
      r_mask    <= 1'b0;
      r_led_q   <= 1'b0;
      r_div     <= '0;
      r_wren    <= 1'b0;
      r_ack     <= 1'b0;
      r_wrap    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_step    <= w_step;
      r_tog_cnt <= w_tog_cnt;
      r_mask    <= w_mask;
      r_led_q   <= led_i;
      r_div     <= w_div;
      r_wren    <= w_wren;
      r_ack     <= w_ack;
      r_wrap    <= w_wrap;
      r_busy    <= (w_nxt_state != IDLE);
    end
  end

  // Override requests beat both enable and step completion so software never waits on the table
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE: begin
        if (sw_req_i)  w_nxt_state = SW;
        else if (en_i) w_nxt_state = LOAD;
      end
      LOAD: w_nxt_state = en_i ? RUN : IDLE;
      RUN: begin
        if (sw_req_i)   w_nxt_state = SW;
        else if (!en_i) w_nxt_state = IDLE;
        else if (w_done) w_nxt_state = LOAD;
      end
      SW: begin
        if (!sw_req_i) w_nxt_state = en_i ? LOAD : IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Reload strobes fire on the edge that leaves LOAD or enters SW, so every output stays registered
  always_comb begin
    w_step    = r_step;
    w_tog_cnt = r_tog_cnt;
    w_mask    = r_mask;
    w_div     = r_div;
    w_wren    = 1'b0;
    w_ack     = 1'b0;
    w_wrap    = 1'b0;
    if (w_nxt_state == SW && r_state != SW) begin
      w_div  = sw_div_i;
      w_wren = 1'b1;
      w_ack  = 1'b1;
    end else if (w_nxt_state == IDLE) begin
      w_step = '0;
    end else if (r_state == LOAD) begin
      w_div     = w_tab_div;
      w_wren    = 1'b1;
      w_tog_cnt = '0;
      w_mask    = 1'b1;
    end else if (r_state == RUN && w_done) begin
      if (r_step == STEP_W'(NSTEPS-1)) begin
        w_step = '0;
        w_wrap = 1'b1;
      end else begin
        w_step = r_step + STEP_W'(1);
      end
    end else if (r_state == RUN && w_toggle) begin
      if (r_mask) w_mask    = 1'b0;
      else        w_tog_cnt = w_cnt_inc[HOLD_W-1:0];
    end
  end

  assign div_o    = r_div;
  assign wren_o   = r_wren;
  assign sw_ack_o = r_ack;
  assign wrap_o   = r_wrap;
  assign step_o   = r_step;
  assign busy_o   = r_busy;

`ifdef LED_SEQ_AUTOCLR_EN
  logic r_int_clr;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) r_int_clr <= 1'b0;
    else        r_int_clr <= int_i;
  end

  assign int_clr_o = r_int_clr;
`else
  logic w_unused;

  assign w_unused  = int_i;
  assign int_clr_o = 1'b0;
`endif

endmodule

// File: tb/tb_led_div_seq.sv
// Self-checking bench for led_div_seq: cycle-by-cycle reference model plus directed literal checks.
// Honours LED_SEQ_AUTOCLR_EN the same way as the design.
module tb_led_div_seq;

  localparam int NSTEPS = 4;
  localparam int DIV_W  = 12;
  localparam int HOLD_W = 8;

  logic                     clk100;
  logic                     rst_n;
  logic                     en_i;
  logic [NSTEPS*DIV_W-1:0]  step_div_i;
  logic [NSTEPS*HOLD_W-1:0] step_hold_i;
  logic                     sw_req_i;
  logic [DIV_W-1:0]         sw_div_i;
  logic                     sw_ack_o;
  logic                     led_i;
  logic                     int_i;
  logic                     int_clr_o;
  logic [DIV_W-1:0]         div_o;
  logic                     wren_o;
  logic [1:0]               step_o;
  logic                     busy_o;
  logic                     wrap_o;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 0;

  led_div_seq #(.NSTEPS(NSTEPS), .DIV_W(DIV_W), .HOLD_W(HOLD_W)) dut (
    .clk100(clk100), .rst_n(rst_n), .en_i(en_i),
    .step_div_i(step_div_i), .step_hold_i(step_hold_i),
    .sw_req_i(sw_req_i), .sw_div_i(sw_div_i), .sw_ack_o(sw_ack_o),
    .led_i(led_i), .int_i(int_i), .int_clr_o(int_clr_o),
    .div_o(div_o), .wren_o(wren_o), .step_o(step_o),
    .busy_o(busy_o), .wrap_o(wrap_o)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  // Reference model: modes 0 idle, 1 load pending, 2 running, 3 software owned
  int         mMode;
  int         mStep;
  int         mRemain;
  bit         mSkip;
  bit         mTog;
  logic       mPrevLed;
  logic [11:0] expDiv;
  bit         expWren, expAck, expWrap, expIntClr;

  function automatic int holdOf(int k);
    int h;
    h = int'(step_hold_i[k*HOLD_W +: HOLD_W]);
    return (h == 0) ? 1 : h;
  endfunction

  always @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      mMode = 0; mStep = 0; mRemain = 0; mSkip = 0; mPrevLed = 1'b0;
      expDiv = '0; expWren = 0; expAck = 0; expWrap = 0; expIntClr = 0;
    end else begin
      mTog = (led_i != mPrevLed);
      mPrevLed = led_i;
      expWren = 0; expAck = 0; expWrap = 0;
`ifdef LED_SEQ_AUTOCLR_EN
      expIntClr = int_i;
`endif
      case (mMode)
        0: begin
          if (sw_req_i) begin
            mMode = 3; expDiv = sw_div_i; expWren = 1; expAck = 1;
          end else if (en_i) begin
            mMode = 1; mStep = 0;
          end
        end
        1: begin
          if (!en_i) begin
            mMode = 0; mStep = 0;
          end else begin
            expDiv = step_div_i[mStep*DIV_W +: DIV_W];
            expWren = 1; mRemain = holdOf(mStep); mSkip = 1; mMode = 2;
          end
        end
        2: begin
          if (sw_req_i) begin
            mMode = 3; expDiv = sw_div_i; expWren = 1; expAck = 1;
          end else if (!en_i) begin
            mMode = 0; mStep = 0;
          end else if (mTog) begin
            if (mSkip) mSkip = 0;
            else begin
              mRemain = mRemain - 1;
              if (mRemain == 0) begin
                mMode = 1;
                if (mStep == NSTEPS-1) begin mStep = 0; expWrap = 1; end
                else mStep = mStep + 1;
              end
            end
          end
        end
        default: begin
          if (!sw_req_i) begin
            if (en_i) mMode = 1;
            else begin mMode = 0; mStep = 0; end
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk100) begin
    #1;
    if (rst_n && cmpEn) begin
      checks++;
      if ({div_o, wren_o, sw_ack_o, wrap_o, step_o, busy_o, int_clr_o} !==
          {expDiv, expWren, expAck, expWrap, 2'(mStep), (mMode != 0), expIntClr}) begin
        failures++;
        $display("[TB] FAIL model t=%0t actual div=%h wren=%b ack=%b wrap=%b step=%0d busy=%b clr=%b required div=%h wren=%b ack=%b wrap=%b step=%0d busy=%b clr=%b",
                 $time, div_o, wren_o, sw_ack_o, wrap_o, step_o, busy_o, int_clr_o,
                 expDiv, expWren, expAck, expWrap, mStep, (mMode != 0), expIntClr);
      end
    end
  end

  logic [11:0] wrenLog[$];
  int          wrapCount = 0;

  always @(posedge clk100) begin
    #1;
    if (rst_n && wren_o) wrenLog.push_back(div_o);
    if (rst_n && wrap_o) wrapCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic req, input logic [11:0] swDiv);
    en_i = en; sw_req_i = req; sw_div_i = swDiv;
  endtask

  task automatic toggleLed(input int gap);
    led_i = ~led_i;
    repeat (gap) @(negedge clk100);
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk100);
  endtask

  initial begin
    logic [11:0] expSeq [5];
    expSeq = '{12'h02B, 12'h055, 12'h080, 12'h0FF, 12'h02B};
    rst_n = 1'b0; led_i = 1'b0; int_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'h000);
    step_div_i  = {12'h0FF, 12'h080, 12'h055, 12'h02B};
    step_hold_i = {8'd1, 8'd3, 8'd1, 8'd2};
    waitNeg(3);
    checkOutput("reset_div", 32'(div_o), 32'h0);
    checkOutput("reset_flags", {27'd0, wren_o, sw_ack_o, wrap_o, busy_o, int_clr_o}, 32'h0);
    checkOutput("reset_step", 32'(step_o), 32'h0);
    rst_n = 1'b1; cmpEn = 1;
    waitNeg(1);

    $display("[TB] table sequence");
    applyStimulus(1'b1, 1'b0, 12'h000);
    waitNeg(1);
    checkOutput("load_no_wren_yet", {30'd0, busy_o, wren_o}, 32'h2);
    waitNeg(1);
    checkOutput("first_wren", {19'd0, wren_o, div_o}, {19'd0, 1'b1, 12'h02B});
    for (int i = 0; i < 11; i++) toggleLed(4);
    checkOutput("wren_count", 32'(wrenLog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < wrenLog.size()) checkOutput($sformatf("wren_div_%0d", i), 32'(wrenLog[i]), 32'(expSeq[i]));
    checkOutput("wrap_count", 32'(wrapCount), 32'd1);
    checkOutput("step_after_wrap", 32'(step_o), 32'd0);

    $display("[TB] software override");
    for (int i = 0; i < 3; i++) toggleLed(4);
    applyStimulus(1'b1, 1'b1, 12'h010);
    waitNeg(1);
    checkOutput("sw_grant", {16'd0, wren_o, sw_ack_o, step_o, div_o}, {16'd0, 1'b1, 1'b1, 2'd1, 12'h010});
    waitNeg(1);
    checkOutput("sw_ack_single", {30'd0, sw_ack_o, wren_o}, 32'h0);
    toggleLed(1);
    toggleLed(1);
    applyStimulus(1'b1, 1'b0, 12'h010);
    waitNeg(1);
    checkOutput("release_load", 32'(wren_o), 32'h0);
    waitNeg(1);
    checkOutput("release_reload", {18'd0, wren_o, step_o, div_o}, {18'd0, 1'b1, 2'd1, 12'h055});

    $display("[TB] override against completing toggle");
    rst_n = 1'b0; led_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'h010);
    waitNeg(2);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 12'h010);
    waitNeg(2);
    toggleLed(4);
    toggleLed(4);
    led_i = ~led_i;
    applyStimulus(1'b1, 1'b1, 12'h010);
    waitNeg(1);
    checkOutput("race_sw_wins", {17'd0, sw_ack_o, step_o, div_o}, {17'd0, 1'b1, 2'd0, 12'h010});
    waitNeg(2);
    applyStimulus(1'b1, 1'b0, 12'h010);
    waitNeg(2);
    checkOutput("race_step_kept", {18'd0, wren_o, step_o, div_o}, {18'd0, 1'b1, 2'd0, 12'h02B});

    $display("[TB] enable drop");
    for (int i = 0; i < 6; i++) toggleLed(4);
    checkOutput("at_step2", 32'(step_o), 32'd2);
    applyStimulus(1'b0, 1'b0, 12'h010);
    waitNeg(1);
    checkOutput("en_drop", {17'd0, busy_o, wren_o, step_o, div_o}, {17'd0, 1'b0, 1'b0, 2'd0, 12'h080});

    $display("[TB] reset during load");
    applyStimulus(1'b1, 1'b0, 12'h010);
    @(posedge clk100);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", {18'd0, wren_o, busy_o, div_o}, 32'h0);
    waitNeg(1);
    applyStimulus(1'b0, 1'b0, 12'h010);
    waitNeg(1);
    rst_n = 1'b1;
    waitNeg(2);
    checkOutput("idle_after_reset", {30'd0, busy_o, wren_o}, 32'h0);

    $display("[TB] interrupt clear");
    int_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      waitNeg(1);
`ifdef LED_SEQ_AUTOCLR_EN
      checkOutput($sformatf("int_clr_%0d", k), 32'(int_clr_o), (k <= 3) ? 32'd1 : 32'd0);
`else
      checkOutput($sformatf("int_clr_%0d", k), 32'(int_clr_o), 32'd0);
`endif
      if (k == 3) int_i = 1'b0;
    end

    $display("[TB] zero hold count");
    step_hold_i = {8'd1, 8'd3, 8'd1, 8'd0};
    applyStimulus(1'b1, 1'b0, 12'h010);
    waitNeg(2);
    toggleLed(4);
    toggleLed(4);
    checkOutput("hold0_advance", {18'd0, step_o, div_o}, {18'd0, 2'd1, 12'h055});
    applyStimulus(1'b0, 1'b0, 12'h010);
    waitNeg(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
